spi_loader: RTL
===============

# spi_loader

SPI-slave program/data loader sitting directly upstream of the instruction and data caches. It deserializes bytes sent by the external master on MOSI while a chip-select frame is active. Each complete byte becomes a one-cycle write strobe, with an auto-incrementing address, into the cache chosen by the 2-bit target select. It replaces the ad-hoc RECV handling so the control FSM only sees `busy_out`.

## Interface

Parameters:
- `DATA_W`, default `DATAPATH_W` (8): byte width shifted per write.
- `ADDR_W`, default 4: cache address width.
- `DEPTH`, default 16: number of writable locations per frame.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `sclk_in`  in  1  SPI clock from master, asynchronous, mode 0.
- `cs_n_in`  in  1  frame select, active-low, asynchronous.
- `mosi_in`  in  1  serial data, MSB first.
- `sel_in`  in  2  target: 2'b01 icache, 2'b10 dcache; 00/11 invalid.
- `miso_out`  out  1  echo bit (see Configuration).
- `addr_out`  out  ADDR_W  cache write address.
- `data_out`  out  DATA_W  cache write data.
- `icache_wen_out`  out  1  one-cycle icache write strobe.
- `dcache_wen_out`  out  1  one-cycle dcache write strobe.
- `busy_out`  out  1  high from frame start to frame end.
- `overflow_out`  out  1  sticky: a byte arrived after `DEPTH` writes in this frame.

## Operation

- Input handling: `sclk_in` and `cs_n_in` pass through a 2-flop synchronizer with edge detect; `mosi_in` passes through a 2-flop synchronizer with no edge detect.
- States:
  - ARM: waiting for synced `cs_n` high. This is the state entered after reset.
  - IDLE
  - SHIFT
  - COMMIT
  - FULL
  - IGNORE
- ARM → IDLE when synced `cs_n` is high, so a reset that occurs mid-frame never starts mid-byte.
- IDLE → on a `cs_n` falling edge:
  - `sel_in` valid: latch the target, `addr`=0, `bit_cnt`=0, clear `overflow_out`, go to SHIFT.
  - `sel_in` invalid: go to IGNORE.
- SHIFT, on each `sclk` rising edge: `shreg` = {`shreg`[DATA_W-2:0], `mosi`}, `bit_cnt`++. On the DATA_W-th edge go to COMMIT.
- COMMIT (one cycle):
  - Assert the latched target's wen, with `data_out`=`shreg` and `addr_out`=`addr`.
  - If `addr`==DEPTH-1, go to FULL.
  - Otherwise `addr`++, `bit_cnt`=0, and go to SHIFT.
- FULL: further complete bytes are dropped and set `overflow_out`=1. No wen is asserted.
- IGNORE: no writes, no overflow.
- A `cs_n` rising edge in SHIFT, FULL or IGNORE → IDLE. A partial byte is discarded.
- Changes to `sel_in` after frame start are ignored.
- Simultaneous events: if the DATA_W-th edge and the `cs_n` rise are detected in the same cycle, the byte is committed, then the block returns to IDLE.
- `busy_out` = state ∉ {IDLE, ARM}.
- `addr_out`/`data_out` hold their last values outside COMMIT.

## Timing

- Reset values: all outputs 0; state ARM; `addr`, `bit_cnt` and `shreg` all 0.
- Pin-to-detect latency: 3 `clk` cycles (2 sync + 1 edge register).
- Wen is asserted in the `clk` cycle immediately after the cycle in which the DATA_W-th `sclk` rise is detected. Wen is exactly 1 cycle wide.
- `busy_out` rises 1 cycle after the `cs_n` fall is detected, and falls 1 cycle after the `cs_n` rise is detected.
- Constraint: `sclk` high and low phases each last at least 3 `clk` periods. `cs_n` setup to the first `sclk` rise is at least 3 `clk` periods. Behaviour is unspecified outside these limits.
- Address wrap: never. `addr` saturates at DEPTH-1 and FULL is entered.

## Configuration

- `SPI_LOADER_ECHO_EN` defined:
  - On each COMMIT, a DATA_W-bit output register is loaded with the committed byte.
  - `miso_out` shifts that register out MSB first.
  - The register advances on each detected `sclk` falling edge during SHIFT.
  - The first byte of a frame echoes 0.
  - Net effect: byte N is echoed while byte N+1 is received.
- Macro undefined: `miso_out` is tied to 0 and the output register is not built.

## Structure

- Shared defs header holds:
  - `DATAPATH_W`, `IMEM_SZ`, `DMEM_SZ`, `CLOG2`.
  - Target encodings `LOADER_SEL_ICACHE`=2'b01 and `LOADER_SEL_DCACHE`=2'b10.
  - The state encoding localparams.
- One sub-module, `sync_edge`: a 2-flop synchronizer with registered `rise_out`/`fall_out`. It is instantiated for `sclk` and `cs_n`.

## Test plan

- `sel`=01, send 0xA5, 0x3C → icache writes (0,0xA5) and (1,0x3C), each one cycle wide; `busy_out` drops 1 cycle after the `cs_n` rise is detected.
- `sel`=10, 17 bytes 0x00..0x10 → dcache writes 0..15 with data 0x00..0x0F; `overflow_out`=1 after byte 17; no 17th wen.
- `cs_n` raised after 5 bits of a second byte → only the first byte is written; the next frame starts at address 0 with no stale bits.
- `sel`=11 frame with 3 bytes → no wen, `overflow_out` stays 0, `busy_out`=1 during the frame; `sel` flipped 01→10 mid-frame → all writes go to icache.
- `rst` pulsed mid-frame while `cs_n` stays low → outputs 0; bytes after reset are ignored until `cs_n` goes high; the next frame writes from address 0.
- `SPI_LOADER_ECHO_EN`: send 0x81, 0x42 → `miso_out` shows 0x00 during byte 1 and 0x81 during byte 2. Without the macro, `miso_out` stays 0.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI cache loader: widths, target encodings and FSM states.
package spi_loader_pkg;

    localparam int DATAPATH_W = 8;
    localparam int IMEM_SZ    = 16;
    localparam int DMEM_SZ    = 16;

    localparam logic [1:0] LOADER_SEL_ICACHE = 2'b01;
    localparam logic [1:0] LOADER_SEL_DCACHE = 2'b10;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_FULL,
        ST_IGNORE
    } state_e;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_loader_if.sv
// SPI pins plus the cache write bus of the loader; slave = loader side, master = driver side.
interface spi_loader_if
    import spi_loader_pkg::*;
#(
    parameter int DATA_W = DATAPATH_W,
    parameter int ADDR_W = 4
);
    logic              sclk_in;
    logic              cs_n_in;
    logic              mosi_in;
    logic [1:0]        sel_in;
    logic              miso_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              icache_wen_out;
    logic              dcache_wen_out;
    logic              busy_out;
    logic              overflow_out;

    modport slave (
        input  sclk_in, cs_n_in, mosi_in, sel_in,
        output miso_out, addr_out, data_out, icache_wen_out, dcache_wen_out,
               busy_out, overflow_out
    );

    modport master (
        output sclk_in, cs_n_in, mosi_in, sel_in,
        input  miso_out, addr_out, data_out, icache_wen_out, dcache_wen_out,
               busy_out, overflow_out
    );
endinterface

// File: rtl/spi_loader_sync_edge.sv
// Two-flop synchronizer followed by registered rising/falling edge pulses.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise_out,
    output logic fall_out
);
    logic meta_q, sync_q, prev_q, rise_q, fall_q;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is three stages deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign rise_out = rise_q;
    assign fall_out = fall_q;
endmodule

// File: rtl/spi_loader.sv
// SPI-slave byte loader writing auto-incrementing addresses into the icache or dcache.
// Optional MISO echo of the previous byte is built when SPI_LOADER_ECHO_EN is defined.
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int DATA_W = DATAPATH_W,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic       clk,
    input logic       rst,
    spi_loader_if.slave bus
);
    localparam int CNT_W = (CLOG2(DATA_W) < 1) ? 1 : CLOG2(DATA_W);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_meta_q, mosi_q;

    sync_edge u_sclk_sync (.clk(clk), .rst(rst), .d_in(bus.sclk_in),
                           .rise_out(sclk_rise), .fall_out(sclk_fall));
    sync_edge u_cs_sync   (.clk(clk), .rst(rst), .d_in(bus.cs_n_in),
                           .rise_out(cs_rise), .fall_out(cs_fall));

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= bus.mosi_in;
            mosi_q      <= mosi_meta_q;
        end
    end

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, addr_out_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shreg_q, data_q;
    logic [1:0]        target_q;
    logic              iwen_q, dwen_q, ovf_q, end_q;
`ifdef SPI_LOADER_ECHO_EN
    logic [DATA_W-1:0] echo_q;
`endif

    logic [DATA_W-1:0] shreg_next;
    logic              last_bit;
    assign shreg_next = {shreg_q[DATA_W-2:0], mosi_q};
    assign last_bit   = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARM;
            addr_q     <= '0;
            addr_out_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            target_q   <= '0;
            iwen_q     <= 1'b0;
            dwen_q     <= 1'b0;
            ovf_q      <= 1'b0;
            end_q      <= 1'b0;
`ifdef SPI_LOADER_ECHO_EN
            echo_q     <= '0;
`endif
        end else begin
            iwen_q <= 1'b0;
            dwen_q <= 1'b0;
            case (state_q)
                // Synced cs_n resets low, so a rise here means the master is idle.
                ST_ARM: if (cs_rise) state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (cs_fall) begin
                        if (bus.sel_in == LOADER_SEL_ICACHE || bus.sel_in == LOADER_SEL_DCACHE) begin
                            target_q  <= bus.sel_in;
                            addr_q    <= '0;
                            bit_cnt_q <= '0;
                            shreg_q   <= '0;
                            ovf_q     <= 1'b0;
                            end_q     <= 1'b0;
`ifdef SPI_LOADER_ECHO_EN
                            echo_q    <= '0;
`endif
                            state_q   <= ST_SHIFT;
                        end else begin
                            state_q <= ST_IGNORE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        shreg_q   <= shreg_next;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (sclk_rise && last_bit) begin
                        iwen_q     <= (target_q == LOADER_SEL_ICACHE);
                        dwen_q     <= (target_q == LOADER_SEL_DCACHE);
                        data_q     <= shreg_next;
                        addr_out_q <= addr_q;
                        end_q      <= cs_rise;
`ifdef SPI_LOADER_ECHO_EN
                        echo_q     <= shreg_next;
`endif
                        state_q    <= ST_COMMIT;
                    end else if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end
`ifdef SPI_LOADER_ECHO_EN
                    // The trailing fall of the previous byte arrives with bit_cnt at 0 and must not shift.
                    if (sclk_fall && bit_cnt_q != '0) echo_q <= {echo_q[DATA_W-2:0], 1'b0};
`endif
                end
                ST_COMMIT: begin
                    bit_cnt_q <= '0;
                    if (end_q || cs_rise) begin
                        state_q <= ST_IDLE;
                    end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_FULL;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_FULL: begin
                    if (sclk_rise) begin
                        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
                        if (last_bit) ovf_q <= 1'b1;
                    end
                    if (cs_rise) state_q <= ST_IDLE;
                end
                ST_IGNORE: if (cs_rise) state_q <= ST_IDLE;
                default:   state_q <= ST_ARM;
            endcase
        end
    end

    assign bus.addr_out       = addr_out_q;
    assign bus.data_out       = data_q;
    assign bus.icache_wen_out = iwen_q;
    assign bus.dcache_wen_out = dwen_q;
    assign bus.overflow_out   = ovf_q;
    assign bus.busy_out       = (state_q != ST_IDLE) && (state_q != ST_ARM);

`ifdef SPI_LOADER_ECHO_EN
    assign bus.miso_out = echo_q[DATA_W-1];
`else
    logic sclk_fall_unused;
    assign sclk_fall_unused = sclk_fall;
    assign bus.miso_out     = 1'b0;
`endif
endmodule
